// File: rtl/irq_pkg.sv
// Shared constants for the interrupt arbiter: cause codes, eligibility bit
// positions and the 3-bit FSM state encoding.
package irq_pkg;

   localparam int CW = 4;

   localparam logic [3:0] CAUSE_EXT = 4'd11;
   localparam logic [3:0] CAUSE_SFT = 4'd3;
   localparam logic [3:0] CAUSE_TMR = 4'd7;

   localparam int ELIG_TMR = 0;
   localparam int ELIG_SFT = 1;
   localparam int ELIG_EXT = 2;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_DEFER   = 3'd1;
   localparam logic [2:0] ST_REQ     = 3'd2;
   localparam logic [2:0] ST_HANDLER = 3'd3;
   localparam logic [2:0] ST_COOL    = 3'd4;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder turning the eligible interrupt set into a cause
// code (ext > sft > tmr) plus a valid flag.
module irq_prio_enc #(
   parameter int CW = 4
) (
   input  logic [2:0]    elig_i,
   output logic          valid_o,
   output logic [CW-1:0] cause_o
);
   import irq_pkg::*;

   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      valid_o = |elig_i;
      cause_o = '0;
      if (elig_i[ELIG_EXT])      cause_o = CW'(CAUSE_EXT);
      else if (elig_i[ELIG_SFT]) cause_o = CW'(CAUSE_SFT);
      else if (elig_i[ELIG_TMR]) cause_o = CW'(CAUSE_TMR);
   end

endmodule

// File: rtl/irq_arbiter.sv
// Interrupt sequencer: qualifies pending levels, defers across flushes,
// runs a single-outstanding req/ack handshake and a post-mret hold-off.
module irq_arbiter #(
   parameter int HOLDOFF = 2,
   parameter int CW      = irq_pkg::CW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          irq_i_tmr,
   input  logic          irq_i_sft,
   input  logic          irq_i_ext,
   input  logic          irq_i_mtie,
   input  logic          irq_i_msie,
   input  logic          irq_i_meie,
   input  logic          irq_i_gie,
   input  logic          irq_i_bjp_flush,
   input  logic          irq_i_retire,
   input  logic          irq_i_ack,
   input  logic          irq_i_mret,
   output logic          irq_o_req,
   output logic [CW-1:0] irq_o_cause,
   output logic          irq_o_pc_sel,
   output logic          irq_o_ext_ack,
   output logic          irq_o_busy
);
   import irq_pkg::*;

   localparam logic [3:0] HOLD_LOAD = 4'(HOLDOFF - 1);

   logic [2:0]    elig;
   logic          enc_valid;
   logic [CW-1:0] enc_cause;

   logic [2:0]    state_q, state_d;
   logic [CW-1:0] cause_q, cause_d;
   logic          pc_sel_q, pc_sel_d;
   logic          req_q, req_d;
   logic          ext_ack_q, ext_ack_d;
   logic          busy_q, busy_d;
   logic [3:0]    cnt_q, cnt_d;

   assign elig = {irq_i_ext & irq_i_meie,
                  irq_i_sft & irq_i_msie,
                  irq_i_tmr & irq_i_mtie} & {3{irq_i_gie}};

   irq_prio_enc #(.CW(CW)) u_prio_enc (
      .elig_i  (elig),
      .valid_o (enc_valid),
      .cause_o (enc_cause)
   );

   always_comb begin
      state_d   = state_q;
      cause_d   = cause_q;
      pc_sel_d  = pc_sel_q;
      cnt_d     = cnt_q;
      ext_ack_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            // A flush takes precedence: the interrupted pc is the one being flushed to.
            if (enc_valid && irq_i_bjp_flush) begin
               state_d  = ST_DEFER;
               cause_d  = enc_cause;
               pc_sel_d = 1'b1;
            end else if (enc_valid && irq_i_retire) begin
               state_d  = ST_REQ;
               cause_d  = enc_cause;
               pc_sel_d = 1'b0;
            end
         end
         ST_DEFER: begin
            if (!irq_i_bjp_flush && irq_i_retire) state_d = ST_REQ;
         end
         ST_REQ: begin
            if (irq_i_ack) begin
               state_d   = ST_HANDLER;
               ext_ack_d = (cause_q == CW'(CAUSE_EXT));
            end
         end
         ST_HANDLER: begin
            if (irq_i_mret) begin
               state_d = ST_COOL;
               cnt_d   = HOLD_LOAD;
            end
         end
         ST_COOL: begin
            if (cnt_q == '0) state_d = ST_IDLE;
            else             cnt_d   = cnt_q - 4'd1;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign req_d  = (state_d == ST_REQ);
   assign busy_d = (state_d == ST_HANDLER) || (state_d == ST_COOL);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         cause_q   <= '0;
         pc_sel_q  <= 1'b0;
         req_q     <= 1'b0;
         ext_ack_q <= 1'b0;
         busy_q    <= 1'b0;
         cnt_q     <= '0;
      end else begin
         // NOTE: non-blocking updates so every flop samples pre-edge values.
         state_q   <= state_d;
         cause_q   <= cause_d;
         pc_sel_q  <= pc_sel_d;
         req_q     <= req_d;
         ext_ack_q <= ext_ack_d;
         busy_q    <= busy_d;
         cnt_q     <= cnt_d;
      end
   end

   assign irq_o_req     = req_q;
   assign irq_o_cause   = cause_q;
   assign irq_o_pc_sel  = pc_sel_q;
   assign irq_o_ext_ack = ext_ack_q;
   assign irq_o_busy    = busy_q;

endmodule
